des_key_schedule: RTL and testbench
===================================

Name: des_key_schedule

Overview:
- Upstream producer of the per-round subkey Kn consumed by the DES round function.
- Loads a 64-bit DES key and applies PC-1 to form the 28-bit halves C and D.
- Steps through 16 iterations on request, rotating C and D per the DES shift schedule and presenting PC-2(C,D) as Kn.
- Supports encrypt order (K1..K16) and decrypt order (K16..K1).

Parameters:
- ROUNDS, 16, number of iterations per key; fixed by DES, not to be overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- start  input  1  pulse: latch key_in and decrypt, begin a new schedule.
- decrypt  input  1  sampled with start; 1 = emit subkeys in reverse order.
- key_in  input  [1:64]  DES key, bit 1 = MSB; parity bits 8,16,..,64 ignored.
- next  input  1  consumer has used the current Kn; advance to the next iteration.
- Kn  output  [1:48]  subkey for the current iteration.
- round  output  [4:0]  current iteration index 1..16; 0 when idle.
- key_valid  output  1  Kn and round are valid.
- last  output  1  high while key_valid and round==16.

Behaviour:
- Reset (rst high at a clk edge): state=IDLE, C=D=0, round=0, key_valid=0, last=0, Kn=PC-2(0)=0.
- States: IDLE and ACTIVE; 5-bit round register; 28-bit C and D registers; dir register.
- Kn is combinational PC-2 of the C and D registers. No added latency beyond the registers.
- start (any state): next cycle state=ACTIVE, round=1, key_valid=1, dir=decrypt.
  - Encrypt: C,D = PC-1 halves each rotated left by 1, i.e. C1,D1.
  - Decrypt: C,D = PC-1 halves unrotated; C0=C16, so Kn=K16.
- Latency: start to the first valid Kn is 1 cycle.
- next while ACTIVE and round<16: round+1 on the next cycle.
  - Encrypt: rotate left by s(round+1).
  - Decrypt: rotate right by s(17-round).
  - s(i)=1 for i in {1,2,9,16}, otherwise 2.
- next while ACTIVE and round==16: next cycle state=IDLE, key_valid=0, last=0, round=0. C and D hold their values.
- next while IDLE: ignored.
- Boundary conditions:
  - start and next in the same cycle: start wins and the schedule restarts at round 1.
  - start mid-schedule: aborts the current schedule and reloads from the new key.
  - rst overrides start and next.
  - Wrap-around: after 16 encrypt rotations, C and D equal the PC-1 halves again (28 total rotation). This is a verification check, not a design dependency.
  - Kn must not change while key_valid=1 and next=0; it holds indefinitely.

Optional Feature:
- Macro DES_KS_DECRYPT_EN.
- Defined: decrypt is honoured as above; the right-rotate path and dir register are present.
- Undefined:
  - The decrypt port remains but is ignored.
  - Only encrypt order is produced; the right-rotate logic and dir register are removed.
  - All timing is identical.

Decomposition:
- Shared des_pkg include file holds:
  - PC-1 and PC-2 index tables.
  - SHIFT_SCHED 16-bit constant (bit i set where s(i)=1).
  - Constants DES_ROUNDS=16, KEY_W=64, SUBKEY_W=48, HALF_W=28.
- One sub-module, pc2_permutation: purely combinational, 56 to 48 bits, same style as the existing permutation primitives.
- PC-1 is inlined in the load path.

Test Plan:
- Encrypt with FIPS key: rst, then start with key_in=64'h133457799BBCDFF1, decrypt=0.
  - Next cycle: key_valid=1, round=1, Kn=48'h1B02EFFC7072.
  - After 1 next: Kn=48'h79AED9DBC9E5.
  - After 15 nexts: round=16, last=1, Kn=48'hCB3D8B0E17F5.
  - 16th next: key_valid=0.
- Decrypt order: same key, decrypt=1.
  - First Kn=48'hCB3D8B0E17F5.
  - Final Kn at round 16 = 48'h1B02EFFC7072.
  - The full sequence equals the encrypt sequence reversed.
- Stall: hold next=0 for 10 cycles at round 5; Kn and round are stable throughout.
  - Random next gaps produce the same 16 subkeys as back-to-back next.
- Restart: assert start with key 64'h0123456789ABCDEF at round 7 while next=1.
  - Next cycle: round=1, and Kn equals the golden-model K1 for the new key.
- Reset mid-operation: rst at round 9 gives round=0, key_valid=0, Kn=0.
  - next while idle keeps all outputs at their reset values.
- Macro off (DES_KS_DECRYPT_EN undefined): start with decrypt=1 yields Kn=48'h1B02EFFC7072 (encrypt order).

Source files
------------

// File: rtl/des_pkg.sv
// Shared DES key-schedule constants: PC-1/PC-2 index tables, shift schedule and
// rotation/permutation helpers used by des_key_schedule and pc2_permutation.
package des_pkg;

  localparam int unsigned DES_ROUNDS = 16;
  localparam int unsigned KEY_W      = 64;
  localparam int unsigned SUBKEY_W   = 48;
  localparam int unsigned HALF_W     = 28;
  localparam int unsigned CD_W       = 2 * HALF_W;

  // Bit (i-1) set where iteration i rotates by one position (i = 1, 2, 9, 16).
  localparam logic [15:0] SHIFT_SCHED = 16'h8103;

  typedef enum logic {
    ST_IDLE,
    ST_ACTIVE
  } ks_state_e;

  typedef struct packed {
    logic [HALF_W-1:0] c;
    logic [HALF_W-1:0] d;
  } cd_t;

  // Entries are 1-based DES bit numbers (bit 1 = MSB of the source word).
  localparam byte unsigned PC1_TABLE [CD_W] = '{
    8'd57, 8'd49, 8'd41, 8'd33, 8'd25, 8'd17, 8'd9,
    8'd1,  8'd58, 8'd50, 8'd42, 8'd34, 8'd26, 8'd18,
    8'd10, 8'd2,  8'd59, 8'd51, 8'd43, 8'd35, 8'd27,
    8'd19, 8'd11, 8'd3,  8'd60, 8'd52, 8'd44, 8'd36,
    8'd63, 8'd55, 8'd47, 8'd39, 8'd31, 8'd23, 8'd15,
    8'd7,  8'd62, 8'd54, 8'd46, 8'd38, 8'd30, 8'd22,
    8'd14, 8'd6,  8'd61, 8'd53, 8'd45, 8'd37, 8'd29,
    8'd21, 8'd13, 8'd5,  8'd28, 8'd20, 8'd12, 8'd4
  };

  localparam byte unsigned PC2_TABLE [SUBKEY_W] = '{
    8'd14, 8'd17, 8'd11, 8'd24, 8'd1,  8'd5,
    8'd3,  8'd28, 8'd15, 8'd6,  8'd21, 8'd10,
    8'd23, 8'd19, 8'd12, 8'd4,  8'd26, 8'd8,
    8'd16, 8'd7,  8'd27, 8'd20, 8'd13, 8'd2,
    8'd41, 8'd52, 8'd31, 8'd37, 8'd47, 8'd55,
    8'd30, 8'd40, 8'd51, 8'd45, 8'd33, 8'd48,
    8'd44, 8'd49, 8'd39, 8'd56, 8'd34, 8'd53,
    8'd46, 8'd42, 8'd50, 8'd36, 8'd29, 8'd32
  };

  function automatic logic [1:0] shift_amt(input logic [4:0] iter);
    return SHIFT_SCHED[4'(iter - 5'd1)] ? 2'd1 : 2'd2;
  endfunction

  function automatic logic [HALF_W-1:0] rol_half(input logic [HALF_W-1:0] x,
                                                 input logic [1:0] n);
    return (n == 2'd1) ? {x[HALF_W-2:0], x[HALF_W-1]}
                       : {x[HALF_W-3:0], x[HALF_W-1:HALF_W-2]};
  endfunction

  function automatic logic [HALF_W-1:0] ror_half(input logic [HALF_W-1:0] x,
                                                 input logic [1:0] n);
    return (n == 2'd1) ? {x[0], x[HALF_W-1:1]}
                       : {x[1:0], x[HALF_W-1:2]};
  endfunction

  function automatic cd_t pc1(input logic [KEY_W-1:0] key);
    logic [CD_W-1:0] cd;
    cd = '0;
    for (int j = 0; j < int'(CD_W); j++) begin
      cd[6'(int'(CD_W) - 1 - j)] = key[6'(int'(KEY_W) - int'(PC1_TABLE[j]))];
    end
    return cd_t'(cd);
  endfunction

endpackage

// File: rtl/pc2_permutation.sv
// PC-2 compression: selects 48 of the 56 C||D bits to form a DES round subkey.
module pc2_permutation
  import des_pkg::*;
(
  input  logic [CD_W-1:0]     cd,
  output logic [SUBKEY_W-1:0] subkey
);

  always_comb begin
    subkey = '0;
    for (int j = 0; j < int'(SUBKEY_W); j++) begin
      subkey[6'(int'(SUBKEY_W) - 1 - j)] = cd[6'(int'(CD_W) - int'(PC2_TABLE[j]))];
    end
  end

  // Positions 9,18,22,25,35,38,43,54 are dropped by PC-2.
  logic unused_cd;
  assign unused_cd = ^{cd[47], cd[38], cd[34], cd[31], cd[21], cd[18], cd[13], cd[2]};

endmodule

// File: rtl/des_key_schedule.sv
// DES per-round subkey generator, encrypt (K1..K16) or decrypt (K16..K1) order.
// Reverse order is built only when DES_KS_DECRYPT_EN is defined.
module des_key_schedule
  import des_pkg::*;
#(
  parameter int unsigned ROUNDS = DES_ROUNDS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        decrypt,
  input  logic [1:64] key_in,
  input  logic        next,
  output logic [1:48] Kn,
  output logic [4:0]  round,
  output logic        key_valid,
  output logic        last
);

  ks_state_e  state_q, state_d;
  logic [4:0] round_q, round_d;
  cd_t        cd_q, cd_d, load_cd;
  logic       last_q, last_d;
`ifdef DES_KS_DECRYPT_EN
  logic       dir_q, dir_d;
`else
  logic       unused_decrypt;
  assign unused_decrypt = decrypt;
`endif

  logic unused_parity;
  assign unused_parity = ^{key_in[8], key_in[16], key_in[24], key_in[32],
                           key_in[40], key_in[48], key_in[56], key_in[64]};

  assign load_cd = pc1(key_in);

  // Next-state: start always wins; next only advances an active schedule.
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    cd_d    = cd_q;
    last_d  = last_q;
`ifdef DES_KS_DECRYPT_EN
    dir_d   = dir_q;
`endif
    if (start) begin
      state_d = ST_ACTIVE;
      round_d = 5'd1;
      last_d  = 1'b0;
      cd_d.c  = rol_half(load_cd.c, 2'd1);
      cd_d.d  = rol_half(load_cd.d, 2'd1);
`ifdef DES_KS_DECRYPT_EN
      dir_d   = decrypt;
      // C0/D0 equals C16/D16, so the unrotated load already yields K16.
      if (decrypt) begin
        cd_d = load_cd;
      end
`endif
    end else if (next && (state_q == ST_ACTIVE)) begin
      if (round_q == 5'(ROUNDS)) begin
        state_d = ST_IDLE;
        round_d = 5'd0;
        last_d  = 1'b0;
      end else begin
        round_d = round_q + 5'd1;
        last_d  = ((round_q + 5'd1) == 5'(ROUNDS));
        cd_d.c  = rol_half(cd_q.c, shift_amt(round_q + 5'd1));
        cd_d.d  = rol_half(cd_q.d, shift_amt(round_q + 5'd1));
`ifdef DES_KS_DECRYPT_EN
        if (dir_q) begin
          cd_d.c = ror_half(cd_q.c, shift_amt(5'(ROUNDS + 1) - round_q));
          cd_d.d = ror_half(cd_q.d, shift_amt(5'(ROUNDS + 1) - round_q));
        end
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      round_q <= 5'd0;
      cd_q    <= '0;
      last_q  <= 1'b0;
`ifdef DES_KS_DECRYPT_EN
      dir_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      cd_q    <= cd_d;
      last_q  <= last_d;
`ifdef DES_KS_DECRYPT_EN
      dir_q   <= dir_d;
`endif
    end
  end

  pc2_permutation u_pc2 (
    .cd     (cd_q),
    .subkey (Kn)
  );

  assign round     = round_q;
  assign key_valid = (state_q == ST_ACTIVE);
  assign last      = last_q;

endmodule

// File: tb/tb_des_key_schedule.sv
// Self-checking bench for des_key_schedule: golden DES key-schedule model feeding
// a per-cycle scoreboard, a vector table, and stall/restart/reset sequences.
module tb_des_key_schedule;

  logic        clk = 1'b0;
  logic        rst, start, decrypt, next;
  logic [1:64] key_in;
  logic [1:48] Kn;
  logic [4:0]  round;
  logic        key_valid, last;

  int checks = 0;
  int errors = 0;

  des_key_schedule dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .decrypt   (decrypt),
    .key_in    (key_in),
    .next      (next),
    .Kn        (Kn),
    .round     (round),
    .key_valid (key_valid),
    .last      (last)
  );

  always #5 clk = ~clk;

  localparam logic [63:0] FIPS_KEY = 64'h133457799BBCDFF1;
  localparam logic [63:0] ALT_KEY  = 64'h0123456789ABCDEF;
  localparam logic [47:0] FIPS_K1  = 48'h1B02EFFC7072;
  localparam logic [47:0] FIPS_K2  = 48'h79AED9DBC9E5;
  localparam logic [47:0] FIPS_K16 = 48'hCB3D8B0E17F5;
`ifdef DES_KS_DECRYPT_EN
  localparam bit DEC_EN = 1'b1;
`else
  localparam bit DEC_EN = 1'b0;
`endif

  localparam int PC1 [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
                              10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                              63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                              14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  localparam int PC2 [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10,
                              23,19,12,4,26,8, 16,7,27,20,13,2,
                              41,52,31,37,47,55, 30,40,51,45,33,48,
                              44,49,39,56,34,53, 46,42,50,36,29,32};
  localparam int SHIFTS [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  // Subkey Kr from scratch: cumulative rotation of C0/D0, then PC-2.
  function automatic logic [47:0] golden(input logic [63:0] key, input int r);
    logic [27:0] c, d;
    logic [55:0] tmp, cd;
    logic [47:0] k;
    int t;
    for (int j = 0; j < 28; j++) begin
      c[27-j] = key[64-PC1[j]];
      d[27-j] = key[64-PC1[j+28]];
    end
    t = 0;
    for (int i = 0; i < r; i++) t += SHIFTS[i];
    t = t % 28;
    tmp = {c, c};
    c = tmp[55-t -: 28];
    tmp = {d, d};
    d = tmp[55-t -: 28];
    cd = {c, d};
    for (int j = 0; j < 48; j++) k[47-j] = cd[56-PC2[j]];
    return k;
  endfunction

  typedef struct {
    logic        valid;
    logic        lst;
    logic [4:0]  rnd;
    logic [47:0] kn;
  } exp_t;
  exp_t sbq[$];

  logic [47:0] m_sched [1:16];
  logic        m_valid, m_dir;
  logic [4:0]  m_round;
  logic [47:0] m_kn;

  function automatic logic [47:0] m_entry(input int r);
    return m_dir ? m_sched[17-r] : m_sched[r];
  endfunction

  // Advance the model on the driven inputs, push the expectation, clock, compare.
  task automatic tick(input string tag);
    exp_t e;
    if (rst) begin
      m_valid = 1'b0; m_round = 5'd0; m_kn = '0;
    end else if (start) begin
      for (int r = 1; r <= 16; r++) m_sched[r] = golden(key_in, r);
      m_dir = decrypt & DEC_EN;
      m_valid = 1'b1; m_round = 5'd1; m_kn = m_entry(1);
    end else if (next && m_valid) begin
      if (m_round == 5'd16) begin
        m_valid = 1'b0; m_round = 5'd0;
      end else begin
        m_round = m_round + 5'd1; m_kn = m_entry(int'(m_round));
      end
    end
    e.valid = m_valid; e.rnd = m_round; e.kn = m_kn;
    e.lst = m_valid && (m_round == 5'd16);
    sbq.push_back(e);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    checks++;
    if (key_valid !== e.valid || round !== e.rnd || Kn !== e.kn || last !== e.lst) begin
      errors++;
      $display("FAIL cycle[%s]: got valid=%b round=%0d Kn=%h last=%b, expected valid=%b round=%0d Kn=%h last=%b",
               tag, key_valid, round, Kn, last, e.valid, e.rnd, e.kn, e.lst);
    end
  endtask

  task automatic cyc(input logic s, input logic d, input logic [63:0] k,
                     input logic n, input logic r, input string tag);
    rst = r; start = s; decrypt = d; key_in = k; next = n;
    tick(tag);
  endtask

  function automatic logic [63:0] junk();
    return {$urandom, $urandom};
  endfunction

  task automatic chk(input string name, input logic [47:0] got_kn, input logic [4:0] got_r,
                     input logic [47:0] exp_kn, input logic [4:0] exp_r);
    checks++;
    if (got_kn !== exp_kn || got_r !== exp_r) begin
      errors++;
      $display("FAIL %s: got Kn=%h round=%0d, expected Kn=%h round=%0d",
               name, got_kn, got_r, exp_kn, exp_r);
    end
  endtask

  typedef struct {
    logic [63:0] key;
    logic        dec;
    int          nexts;
    logic        valid;
    logic        lst;
    logic [4:0]  rnd;
    logic [47:0] kn;
  } vec_t;

  initial begin
    vec_t vecs [7];
    int   cnt;
    vecs[0] = '{FIPS_KEY, 1'b0, 0,  1'b1, 1'b0, 5'd1,  FIPS_K1};
    vecs[1] = '{FIPS_KEY, 1'b0, 1,  1'b1, 1'b0, 5'd2,  FIPS_K2};
    vecs[2] = '{FIPS_KEY, 1'b0, 15, 1'b1, 1'b1, 5'd16, FIPS_K16};
    vecs[3] = '{FIPS_KEY, 1'b0, 16, 1'b0, 1'b0, 5'd0,  FIPS_K16};
    vecs[4] = '{FIPS_KEY, 1'b1, 0,  1'b1, 1'b0, 5'd1,  DEC_EN ? FIPS_K16 : FIPS_K1};
    vecs[5] = '{FIPS_KEY, 1'b1, 1,  1'b1, 1'b0, 5'd2,  DEC_EN ? golden(FIPS_KEY, 15) : FIPS_K2};
    vecs[6] = '{FIPS_KEY, 1'b1, 15, 1'b1, 1'b1, 5'd16, DEC_EN ? FIPS_K1 : FIPS_K16};

    m_dir = 1'b0;
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b1, "reset");
    chk("reset_state", Kn, round, 48'h0, 5'd0);

    foreach (vecs[i]) begin
      cyc(1'b0, 1'b0, junk(), 1'b0, 1'b1, "vec_rst");
      cyc(1'b1, vecs[i].dec, vecs[i].key, 1'b0, 1'b0, "vec_start");
      for (int n = 0; n < vecs[i].nexts; n++) cyc(1'b0, 1'b0, junk(), 1'b1, 1'b0, "vec_next");
      checks++;
      if (Kn !== vecs[i].kn || round !== vecs[i].rnd ||
          key_valid !== vecs[i].valid || last !== vecs[i].lst) begin
        errors++;
        $display("FAIL vec%0d: got Kn=%h round=%0d valid=%b last=%b, expected Kn=%h round=%0d valid=%b last=%b",
                 i, Kn, round, key_valid, last, vecs[i].kn, vecs[i].rnd, vecs[i].valid, vecs[i].lst);
      end
    end

    // Stall at round 5 for 10 cycles, then finish back-to-back.
    cyc(1'b1, 1'b0, FIPS_KEY, 1'b0, 1'b0, "stall_start");
    repeat (4) cyc(1'b0, 1'b0, junk(), 1'b1, 1'b0, "stall_adv");
    repeat (10) cyc(1'b0, 1'b1, junk(), 1'b0, 1'b0, "stall_hold");
    chk("stall_r5", Kn, round, golden(FIPS_KEY, 5), 5'd5);
    repeat (12) cyc(1'b0, 1'b0, junk(), 1'b1, 1'b0, "stall_run");

    // Random next gaps, both orders.
    for (int dir = 0; dir < 2; dir++) begin
      cyc(1'b1, 1'(dir), ALT_KEY, 1'b0, 1'b0, "gap_start");
      cnt = 0;
      while (m_valid && cnt < 200) begin
        cyc(1'b0, 1'b0, junk(), 1'($urandom_range(0, 1)), 1'b0, "gap_run");
        cnt++;
      end
      checks++;
      if (m_valid || key_valid !== 1'b0) begin
        errors++;
        $display("FAIL gap_done: got valid=%b after %0d cycles, expected 0", key_valid, cnt);
      end
    end

    // Restart at round 7 with next held high: start wins.
    cyc(1'b1, 1'b0, FIPS_KEY, 1'b0, 1'b0, "rs_start");
    repeat (6) cyc(1'b0, 1'b0, junk(), 1'b1, 1'b0, "rs_adv");
    cyc(1'b1, 1'b0, ALT_KEY, 1'b1, 1'b0, "rs_restart");
    chk("restart_k1", Kn, round, golden(ALT_KEY, 1), 5'd1);
    repeat (3) cyc(1'b0, 1'b0, junk(), 1'b1, 1'b0, "rs_run");
    chk("restart_k4", Kn, round, golden(ALT_KEY, 4), 5'd4);

    // Reset at round 9 overrides start/next; idle next is ignored.
    cyc(1'b1, 1'b0, FIPS_KEY, 1'b0, 1'b0, "mr_start");
    repeat (8) cyc(1'b0, 1'b0, junk(), 1'b1, 1'b0, "mr_adv");
    cyc(1'b1, 1'b1, ALT_KEY, 1'b1, 1'b1, "mr_reset");
    chk("midreset", Kn, round, 48'h0, 5'd0);
    repeat (3) cyc(1'b0, 1'b0, junk(), 1'b1, 1'b0, "idle_next");
    chk("idle_next", Kn, round, 48'h0, 5'd0);

    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard: got %0d pending entries, expected 0", sbq.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
